// File: rtl/stride_updown_counter_pkg.sv
// Shared constants and helpers for the stride up/down counter.
// Holds the end-mode encodings and the elaboration-time helpers that derive
// the highest sequence value and snap an arbitrary value onto the sequence.
package stride_updown_counter_pkg;

  // End-mode encodings for the sat input
  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT  = 1'b1;

  // Helpers use 32-bit arithmetic, so the counter width is capped here
  localparam int unsigned MAX_WIDTH = 31;

  // Highest value reachable from base in whole strides without exceeding 2**width-1
  function automatic int unsigned last_of(input int unsigned width,
                                          input int unsigned base,
                                          input int unsigned stride);
    int unsigned top_v;
    top_v = (32'd1 << width) - 32'd1;
    return base + stride * ((top_v - base) / stride);
  endfunction

  // Round v down onto the sequence; anything below base becomes base
  function automatic int unsigned snap(input int unsigned v,
                                       input int unsigned base,
                                       input int unsigned stride);
    if (v < base) begin
      return base;
    end
    return base + stride * ((v - base) / stride);
  endfunction

endpackage

// File: rtl/stride_next.sv
// Next-count logic for the stride up/down counter (purely combinational).
// Ports:
//   count_i        current (legal) counter value
//   up_i           direction, 1 = up
//   sat_i          end mode, MODE_WRAP or MODE_SAT
//   en_i           step enable
//   next_count_c_o value the counter takes if no load is pending
//   wrap_c_o       1 when this step wraps from one end to the other
module stride_next
  import stride_updown_counter_pkg::*;
#(
  parameter int unsigned WIDTH  = 4,
  parameter int unsigned BASE   = 1,
  parameter int unsigned STRIDE = 2
) (
  input  logic [WIDTH-1:0] count_i,
  input  logic             up_i,
  input  logic             sat_i,
  input  logic             en_i,
  output logic [WIDTH-1:0] next_count_c_o,
  output logic             wrap_c_o
);

  // One extra bit so count+STRIDE is compared against LAST before truncation
  localparam int unsigned AW     = WIDTH + 1;
  localparam int unsigned LAST   = last_of(WIDTH, BASE, STRIDE);
  localparam logic [AW-1:0] LAST_X   = AW'(LAST);
  localparam logic [AW-1:0] BASE_X   = AW'(BASE);
  localparam logic [AW-1:0] STRIDE_X = AW'(STRIDE);

  logic [AW-1:0]    count_x;
  logic [AW-1:0]    up_sum;
  logic [WIDTH-1:0] dn_diff;
  logic             up_ok;
  logic             dn_ok;

  assign count_x = {1'b0, count_i};
  assign up_sum  = count_x + STRIDE_X;
  assign dn_diff = count_i - WIDTH'(STRIDE);
  assign up_ok   = (up_sum <= LAST_X);
  // Down step is legal only while count sits at least one stride above BASE
  assign dn_ok   = (count_x >= (BASE_X + STRIDE_X));

  // Step, wrap or saturate; hold when not enabled
  always_comb begin
    next_count_c_o = count_i;
    wrap_c_o       = 1'b0;
    if (en_i) begin
      if (up_i) begin
        if (up_ok) begin
          next_count_c_o = up_sum[WIDTH-1:0];
        end else if (sat_i == MODE_WRAP) begin
          next_count_c_o = WIDTH'(BASE);
          wrap_c_o       = 1'b1;
        end
      end else begin
        if (dn_ok) begin
          next_count_c_o = dn_diff;
        end else if (sat_i == MODE_WRAP) begin
          next_count_c_o = WIDTH'(LAST);
          wrap_c_o       = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/stride_updown_counter.sv
// Up/down counter stepping through BASE, BASE+STRIDE, ..., LAST.
// Ports:
//   clk      rising-edge clock
//   reset    asynchronous active-low reset (count -> BASE, wrap -> 0)
//   en       step enable
//   up       direction, 1 = up, 0 = down
//   sat      end mode, 0 = wrap, 1 = saturate
//   load     synchronous load strobe, highest priority
//   load_val value to load, snapped down onto the sequence
//   count    registered counter value, always on the sequence
//   wrap     registered pulse: the previous edge wrapped
//   at_end   combinational: count is at the end in the current direction
module stride_updown_counter
  import stride_updown_counter_pkg::*;
#(
  parameter int unsigned WIDTH  = 4,
  parameter int unsigned BASE   = 1,
  parameter int unsigned STRIDE = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up,
  input  logic             sat,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             wrap,
  output logic             at_end
);

  localparam int unsigned MAXV = (32'd1 << WIDTH) - 32'd1;
  localparam int unsigned LAST = last_of(WIDTH, BASE, STRIDE);

  // Reject illegal parameter sets at elaboration
  if (WIDTH < 2 || WIDTH > MAX_WIDTH) begin : g_bad_width
    $fatal(1, "stride_updown_counter: WIDTH must be in 2..31");
  end
  if (BASE > MAXV) begin : g_bad_base
    $fatal(1, "stride_updown_counter: BASE must be below 2**WIDTH");
  end
  if (STRIDE < 1 || STRIDE > (MAXV - BASE)) begin : g_bad_stride
    $fatal(1, "stride_updown_counter: STRIDE must be in 1..2**WIDTH-1-BASE");
  end

  logic [WIDTH-1:0] count_q, count_d;
  logic             wrap_q, wrap_d;
  logic [WIDTH-1:0] next_count_c;
  logic             wrap_c;
  logic [WIDTH-1:0] load_snap;

  stride_next #(
    .WIDTH  (WIDTH),
    .BASE   (BASE),
    .STRIDE (STRIDE)
  ) u_next (
    .count_i        (count_q),
    .up_i           (up),
    .sat_i          (sat),
    .en_i           (en),
    .next_count_c_o (next_count_c),
    .wrap_c_o       (wrap_c)
  );

  // Snap the load value onto the sequence (divide by a constant)
  assign load_snap = WIDTH'(snap(32'(load_val), BASE, STRIDE));

  // Load mux: load beats any step and never reports a wrap
  always_comb begin
    count_d = next_count_c;
    wrap_d  = wrap_c;
    if (load) begin
      count_d = load_snap;
      wrap_d  = 1'b0;
    end
  end

  // State registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= WIDTH'(BASE);
      wrap_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
    end
  end

  assign count  = count_q;
  assign wrap   = wrap_q;
  assign at_end = up ? (count_q == WIDTH'(LAST)) : (count_q == WIDTH'(BASE));

endmodule

// File: tb/tb_stride_updown_counter.sv
// Self-checking bench: two counters (4/1/2 and 5/0/3) driven by directed
// steps plus a random run; expectations are queued when stimulus is applied
// and compared after the edge.
module tb_stride_updown_counter;

  localparam int BASE_A = 1;
  localparam int STR_A  = 2;
  localparam int LAST_A = 15;
  localparam int MASK_A = 15;
  localparam int BASE_B = 0;
  localparam int STR_B  = 3;
  localparam int LAST_B = 30;
  localparam int MASK_B = 31;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       en_a = 1'b0, up_a = 1'b0, sat_a = 1'b0, load_a = 1'b0;
  logic [3:0] lv_a = '0;
  logic [3:0] count_a;
  logic       wrap_a, at_end_a;
  logic       en_b = 1'b0, up_b = 1'b0, sat_b = 1'b0, load_b = 1'b0;
  logic [4:0] lv_b = '0;
  logic [4:0] count_b;
  logic       wrap_b, at_end_b;

  int checks = 0;
  int failures = 0;
  int m_a = BASE_A;
  int m_b = BASE_B;

  typedef struct {
    string tag;
    int    sel;
    int    cnt;
    int    wr;
    int    ae;
  } exp_t;
  exp_t sb_q[$];

  always #5 clk = ~clk;

  stride_updown_counter #(.WIDTH(4), .BASE(1), .STRIDE(2)) dut_a (
    .clk(clk), .reset(reset), .en(en_a), .up(up_a), .sat(sat_a),
    .load(load_a), .load_val(lv_a), .count(count_a), .wrap(wrap_a),
    .at_end(at_end_a)
  );

  stride_updown_counter #(.WIDTH(5), .BASE(0), .STRIDE(3)) dut_b (
    .clk(clk), .reset(reset), .en(en_b), .up(up_b), .sat(sat_b),
    .load(load_b), .load_val(lv_b), .count(count_b), .wrap(wrap_b),
    .at_end(at_end_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference behaviour of one edge, written from the sequence definition
  function automatic void mdl(input int cur, input bit en, input bit up, input bit sat,
                              input bit ld, input int lv, input int base, input int stride,
                              input int last, output int nxt, output int wr);
    nxt = cur;
    wr  = 0;
    if (ld) begin
      nxt = (lv < base) ? base : base + ((lv - base) / stride) * stride;
    end else if (en) begin
      if (up) begin
        if (cur + stride <= last) nxt = cur + stride;
        else if (!sat) begin nxt = base; wr = 1; end
      end else begin
        if (cur - stride >= base) nxt = cur - stride;
        else if (!sat) begin nxt = last; wr = 1; end
      end
    end
  endfunction

  function automatic int ae_a(input int c);
    return up_a ? int'(c == LAST_A) : int'(c == BASE_A);
  endfunction

  function automatic int ae_b(input int c);
    return up_b ? int'(c == LAST_B) : int'(c == BASE_B);
  endfunction

  task automatic push(input string tag, input int sel, input int cnt, input int wr, input int ae);
    exp_t e;
    e.tag = tag; e.sel = sel; e.cnt = cnt; e.wr = wr; e.ae = ae;
    sb_q.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      if (e.sel == 0) begin
        check({e.tag, "_a_count"}, 32'(count_a), 32'(e.cnt));
        check({e.tag, "_a_wrap"}, 32'(wrap_a), 32'(e.wr));
        check({e.tag, "_a_at_end"}, 32'(at_end_a), 32'(e.ae));
      end else begin
        check({e.tag, "_b_count"}, 32'(count_b), 32'(e.cnt));
        check({e.tag, "_b_wrap"}, 32'(wrap_b), 32'(e.wr));
        check({e.tag, "_b_at_end"}, 32'(at_end_b), 32'(e.ae));
      end
    end
  endtask

  // One clock edge: drive the selected counter, the other holds
  task automatic step(input string tag, input int sel, input bit en_v, input bit up_v,
                      input bit sat_v, input bit ld_v, input int lv);
    int nxt, wr;
    @(negedge clk);
    en_a = 1'b0; load_a = 1'b0; en_b = 1'b0; load_b = 1'b0;
    if (sel == 0) begin
      en_a = en_v; up_a = up_v; sat_a = sat_v; load_a = ld_v; lv_a = 4'(lv & MASK_A);
    end else begin
      en_b = en_v; up_b = up_v; sat_b = sat_v; load_b = ld_v; lv_b = 5'(lv & MASK_B);
    end
    mdl(m_a, en_a, up_a, sat_a, load_a, int'(lv_a), BASE_A, STR_A, LAST_A, nxt, wr);
    m_a = nxt;
    push(tag, 0, m_a, wr, ae_a(m_a));
    mdl(m_b, en_b, up_b, sat_b, load_b, int'(lv_b), BASE_B, STR_B, LAST_B, nxt, wr);
    m_b = nxt;
    push(tag, 1, m_b, wr, ae_b(m_b));
    @(posedge clk);
    #1;
    drain();
  endtask

  initial begin
    int seq[9];
    seq = '{3, 5, 7, 9, 11, 13, 15, 1, 3};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    push("reset", 0, BASE_A, 0, ae_a(BASE_A));
    push("reset", 1, BASE_B, 0, ae_b(BASE_B));
    drain();
    @(negedge clk);
    reset = 1'b1;

    // Count up through the wrap
    for (int i = 0; i < 9; i++) begin
      step("up_seq", 0, 1'b1, 1'b1, 1'b0, 1'b0, 0);
      check("up_seq_const", 32'(count_a), 32'(seq[i]));
      check("up_seq_wrap_const", 32'(wrap_a), (i == 7) ? 32'd1 : 32'd0);
    end

    // Down from BASE in wrap mode, then saturate mode
    step("load1", 0, 1'b0, 1'b0, 1'b0, 1'b1, 1);
    step("dn_wrap", 0, 1'b1, 1'b0, 1'b0, 1'b0, 0);
    check("dn_wrap_const", 32'(count_a), 32'd15);
    step("dn_after", 0, 1'b1, 1'b0, 1'b0, 1'b0, 0);
    check("dn_after_const", 32'(count_a), 32'd13);
    step("load1b", 0, 1'b0, 1'b0, 1'b0, 1'b1, 1);
    step("dn_sat", 0, 1'b1, 1'b0, 1'b1, 1'b0, 0);
    step("dn_sat2", 0, 1'b1, 1'b0, 1'b1, 1'b0, 0);
    check("dn_sat_const", 32'(count_a), 32'd1);

    // Load beats a step that would have wrapped; snapping
    step("ld_en", 0, 1'b1, 1'b0, 1'b0, 1'b1, 0);
    check("ld_en_const", 32'(count_a), 32'd1);
    step("snap8", 0, 1'b0, 1'b1, 1'b0, 1'b1, 8);
    check("snap8_const", 32'(count_a), 32'd7);
    step("snap15", 0, 1'b1, 1'b1, 1'b1, 1'b1, 15);
    step("sat_top", 0, 1'b1, 1'b1, 1'b1, 1'b0, 0);
    check("sat_top_const", 32'(count_a), 32'd15);
    step("hold", 0, 1'b0, 1'b1, 1'b0, 1'b0, 0);

    // Second configuration: LAST=30
    step("b_ld29", 1, 1'b0, 1'b1, 1'b0, 1'b1, 29);
    check("b_ld29_const", 32'(count_b), 32'd27);
    step("b_up", 1, 1'b1, 1'b1, 1'b1, 1'b0, 0);
    step("b_sat", 1, 1'b1, 1'b1, 1'b1, 1'b0, 0);
    check("b_sat_const", 32'(count_b), 32'd30);
    check("b_at_end_const", 32'(at_end_b), 32'd1);
    step("b_wrap", 1, 1'b1, 1'b1, 1'b0, 1'b0, 0);
    step("b_dnwrap", 1, 1'b1, 1'b0, 1'b0, 1'b0, 0);
    check("b_dnwrap_const", 32'(count_b), 32'd30);
    step("b_ld31", 1, 1'b0, 1'b0, 1'b0, 1'b1, 31);

    // Random mix
    for (int i = 0; i < 60; i++) begin
      step("rnd", int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 5) == 0), int'($urandom_range(0, 31)));
    end

    // Asynchronous reset mid-sequence, held across an edge with load and en
    step("ld11", 0, 1'b0, 1'b1, 1'b0, 1'b1, 11);
    check("ld11_const", 32'(count_a), 32'd11);
    #2;
    reset = 1'b0;
    #1;
    m_a = BASE_A;
    m_b = BASE_B;
    push("async_rst", 0, BASE_A, 0, ae_a(BASE_A));
    push("async_rst", 1, BASE_B, 0, ae_b(BASE_B));
    drain();
    @(negedge clk);
    en_a = 1'b1; load_a = 1'b1; lv_a = 4'd9; en_b = 1'b1; load_b = 1'b1; lv_b = 5'd9;
    @(posedge clk);
    #1;
    push("rst_hold", 0, BASE_A, 0, ae_a(BASE_A));
    push("rst_hold", 1, BASE_B, 0, ae_b(BASE_B));
    drain();
    @(negedge clk);
    reset = 1'b1;
    en_a = 1'b0; load_a = 1'b0; en_b = 1'b0; load_b = 1'b0;
    step("post_rst", 0, 1'b1, 1'b1, 1'b0, 1'b0, 0);
    check("post_rst_const", 32'(count_a), 32'd3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/stride_updown_counter.md
STRIDE_UPDOWN_COUNTER -- requirements
Module: stride_updown_counter

Interface
REQ-001 Parameter WIDTH, 4: counter width in bits; SHALL be >= 2.
REQ-002 Parameter BASE, 1: lowest sequence value; SHALL satisfy 0 <= BASE < 2**WIDTH.
REQ-003 Parameter STRIDE, 2: step between sequence values; SHALL satisfy 1 <= STRIDE <= 2**WIDTH-1-BASE.
REQ-004 Derived constant LAST = BASE + STRIDE*floor((2**WIDTH-1-BASE)/STRIDE): highest sequence value.
REQ-005 clk  input  1  clock; all state SHALL update on the rising edge.
REQ-006 reset  input  1  reset, asynchronous, active-low.
REQ-007 en  input  1  count enable; 1 = step on this edge.
REQ-008 up  input  1  direction; 1 = up, 0 = down.
REQ-009 sat  input  1  end mode; 0 = wrap at the ends, 1 = saturate at the ends.
REQ-010 load  input  1  synchronous load strobe.
REQ-011 load_val  input  WIDTH  value to load, snapped per REQ-017.
REQ-012 count  output  WIDTH  registered counter value; always a legal sequence value.
REQ-013 wrap  output  1  registered one-cycle pulse: a wrap occurred on the previous edge.
REQ-014 at_end  output  1  combinational; 1 when count==LAST and up=1, or count==BASE and up=0.

Function
REQ-015 The legal sequence SHALL be {BASE, BASE+STRIDE, ..., LAST}; count SHALL never hold any other value.
REQ-016 Priority per edge SHALL be: load > en > hold.
REQ-017 On load=1, count SHALL take snap(load_val) regardless of en, up or sat. snap(v) = BASE if v < BASE; otherwise BASE + STRIDE*floor((v-BASE)/STRIDE). wrap SHALL be 0 on a load edge.
REQ-018 With en=1, up=1 and count < LAST, count SHALL become count+STRIDE.
REQ-019 With en=1, up=0 and count > BASE, count SHALL become count-STRIDE.
REQ-020 With en=1, up=1, count==LAST and sat=0, count SHALL become BASE and wrap SHALL pulse 1 for the next cycle.
REQ-021 With en=1, up=0, count==BASE and sat=0, count SHALL become LAST and wrap SHALL pulse 1 for the next cycle.
REQ-022 In the end cases of REQ-020 and REQ-021 with sat=1, count SHALL hold and wrap SHALL stay 0.
REQ-023 With en=0 and load=0, count SHALL hold and wrap SHALL be 0.
REQ-024 Arithmetic SHALL be WIDTH+1 bits wide internally so that count+STRIDE cannot overflow silently before the LAST comparison.
REQ-025 Each enabled step SHALL take effect on the same edge (latency 1); up, sat and en are sampled per edge, so the direction can change on any cycle.

Reset
REQ-026 When reset=0, count SHALL asynchronously become BASE and wrap SHALL become 0.
REQ-027 Reset asserted in the middle of a sequence SHALL override load and en.
REQ-028 The first edge after reset deasserts SHALL evaluate normally from count=BASE.

Structure
REQ-029 A shared package SHALL hold the helper functions snap() and last_of(WIDTH, BASE, STRIDE) and the end-mode constants MODE_WRAP=0 and MODE_SAT=1.
REQ-030 One combinational sub-module, stride_next, SHALL compute the next count and the wrap event from count, up, sat and en; the top level SHALL hold only the registers and the load mux.
REQ-031 Elaboration SHALL fail on parameter values that violate REQ-001 to REQ-003.

Verification
REQ-032 WIDTH=4, BASE=1, STRIDE=2: reset, then en=1, up=1 for 9 edges -> count = 3,5,7,9,11,13,15,1,3; wrap=1 only in the cycle after the 15->1 edge.
REQ-033 Same configuration, up=0 from count=1, sat=0 -> count = 15, then 13; wrap pulses once. Repeat with sat=1 -> count stays 1 and wrap stays 0.
REQ-034 WIDTH=5, BASE=0, STRIDE=3 (LAST=30): load=1 with load_val=29 -> count=27; at count=30 with up=1, sat=1 -> count holds 30 and at_end=1.
REQ-035 load=1 and en=1 on the same edge with load_val=0, BASE=1 -> count=1 (load wins, snapped to BASE), wrap=0.
REQ-036 reset pulled low asynchronously at count=11, between clock edges -> count=1 and wrap=0 immediately; the next enabled up edge after release -> count=3.
